// File: rtl/i4003_chain_driver.sv
// Shifts a CHAIN_LEN-bit word MSB-first into cascaded i4003s, then enables outputs; I4003_READBACK_EN adds readback.
// done pulses CHAIN_LEN*(SETUP_CY+HIGH_CY+LOW_CY)+1 cycles after accept; load_ready is low until DONE ends, busy requests dropped.
module i4003_chain_driver #(
  parameter int SYSCLK_TCY         = 20,
  parameter int CHAIN_LEN          = 10,
  parameter int SETUP_NS           = 100,
  parameter int CP_HIGH_NS         = 500,
  parameter int CP_LOW_NS          = 500,
  parameter bit BLANK_DURING_SHIFT = 1'b1
) (
  input  logic                 sysclk,
  input  logic                 rst_n,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [CHAIN_LEN-1:0] load_data,
  output logic                 done,
  output logic                 cp,
  output logic                 serial_data,
  output logic                 enable
`ifdef I4003_READBACK_EN
  ,
  input  logic                 serial_return,
  output logic [CHAIN_LEN-1:0] rd_data
`endif
);

  function automatic int nstocy(input int ns);
    return (ns + SYSCLK_TCY - 1) / SYSCLK_TCY;
  endfunction

  // Every phase lasts at least one cycle so the counter reload never underflows.
  localparam int SETUP_CY = (nstocy(SETUP_NS) < 1) ? 1 : nstocy(SETUP_NS);
  localparam int HIGH_CY  = (nstocy(CP_HIGH_NS) < 1) ? 1 : nstocy(CP_HIGH_NS);
  localparam int LOW_CY   = (nstocy(CP_LOW_NS) < 1) ? 1 : nstocy(CP_LOW_NS);
  localparam int MAX_HL   = (HIGH_CY > LOW_CY) ? HIGH_CY : LOW_CY;
  localparam int MAX_CY   = (SETUP_CY > MAX_HL) ? SETUP_CY : MAX_HL;
  localparam int CNT_W    = (MAX_CY > 1) ? $clog2(MAX_CY) : 1;
  localparam int BIT_W    = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CY - 1);
  localparam logic [CNT_W-1:0] HIGH_LD  = CNT_W'(HIGH_CY - 1);
  localparam logic [CNT_W-1:0] LOW_LD   = CNT_W'(LOW_CY - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, DONE} state_t;

  state_t               state;
  logic [CNT_W-1:0]     phase_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [CHAIN_LEN-1:0] shreg;
  logic [CHAIN_LEN-1:0] shreg_nx;
  logic                 phase_end;
  logic                 frame_end;

  assign shreg_nx  = shreg << 1;
  assign phase_end = (phase_cnt == '0);
  assign frame_end = (state == LOW) && phase_end && (bit_cnt == LAST_BIT);

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      phase_cnt   <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      load_ready  <= 1'b1;
      done        <= 1'b0;
      cp          <= 1'b0;
      serial_data <= 1'b0;
      enable      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_valid && load_ready) begin
            shreg       <= load_data;
            bit_cnt     <= '0;
            phase_cnt   <= SETUP_LD;
            serial_data <= load_data[CHAIN_LEN-1];
            load_ready  <= 1'b0;
            if (BLANK_DURING_SHIFT) enable <= 1'b0;
            state       <= SETUP;
          end
        end
        SETUP: begin
          if (phase_end) begin
            cp        <= 1'b1;
            phase_cnt <= HIGH_LD;
            state     <= HIGH;
          end else begin
            phase_cnt <= phase_cnt - 1'b1;
          end
        end
        HIGH: begin
          if (phase_end) begin
            cp        <= 1'b0;
            phase_cnt <= LOW_LD;
            state     <= LOW;
          end else begin
            phase_cnt <= phase_cnt - 1'b1;
          end
        end
        LOW: begin
          if (phase_end) begin
            shreg <= shreg_nx;
            if (bit_cnt == LAST_BIT) begin
              done        <= 1'b1;
              enable      <= 1'b1;
              serial_data <= 1'b0;
              state       <= DONE;
            end else begin
              bit_cnt     <= bit_cnt + 1'b1;
              serial_data <= shreg_nx[CHAIN_LEN-1];
              phase_cnt   <= SETUP_LD;
              state       <= SETUP;
            end
          end else begin
            phase_cnt <= phase_cnt - 1'b1;
          end
        end
        DONE: begin
          load_ready <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef I4003_READBACK_EN
  // The chain's serial_out has long settled by the end of SETUP, so sample there.
  logic [CHAIN_LEN-1:0] cap;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      cap     <= '0;
      rd_data <= '0;
    end else begin
      if (state == SETUP && phase_end) cap <= (cap << 1) | CHAIN_LEN'(serial_return);
      if (frame_end) rd_data <= cap;
    end
  end
`endif

endmodule

// File: tb/tb_i4003_chain_driver.sv
// Bench for i4003_chain_driver: a one-chip and a two-chip chain, each with a behavioural i4003 chain model.
module tb_i4003_chain_driver;

  logic        sysclk = 1'b0;
  logic        rst_n  = 1'b1;
  logic [1:0]  lv     = '0;
  logic [1:0]  lr, dn, cp_w, sd_w, en_w;
  logic [9:0]  ld0    = '0;
  logic [19:0] ld1    = '0;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #10 sysclk = ~sysclk;

`ifdef I4003_READBACK_EN
  logic        sr0, sr1;
  logic [9:0]  rd0;
  logic [19:0] rd1;
`endif

  i4003_chain_driver #(.CHAIN_LEN(10)) dut0 (
    .sysclk(sysclk), .rst_n(rst_n), .load_valid(lv[0]), .load_ready(lr[0]),
    .load_data(ld0), .done(dn[0]), .cp(cp_w[0]), .serial_data(sd_w[0]), .enable(en_w[0])
`ifdef I4003_READBACK_EN
    , .serial_return(sr0), .rd_data(rd0)
`endif
  );

  i4003_chain_driver #(.CHAIN_LEN(20)) dut1 (
    .sysclk(sysclk), .rst_n(rst_n), .load_valid(lv[1]), .load_ready(lr[1]),
    .load_data(ld1), .done(dn[1]), .cp(cp_w[1]), .serial_data(sd_w[1]), .enable(en_w[1])
`ifdef I4003_READBACK_EN
    , .serial_return(sr1), .rd_data(rd1)
`endif
  );

  // Chain model plus cp/serial_data timing checks; samples on the falling sysclk edge.
  for (genvar g = 0; g < 2; g++) begin : mon
    localparam int LEN = (g == 0) ? 10 : 20;
    localparam logic [19:0] MASK = (g == 0) ? 20'h003FF : 20'hFFFFF;
    logic        bit_q[$];
    logic [19:0] frame_q[$];
    logic [19:0] chain = '0;
    logic        prev_cp = 1'b0, prev_sd = 1'b0, din = 1'b0, en_seen = 1'b0;
    int          rises = 0, high_len = 0, since_rise = 0, stable = 0;

    always @(negedge sysclk) begin
      logic        exp_b;
      logic [19:0] exp_f;
      if (!rst_n) begin
        prev_cp = 1'b0; rises = 0; high_len = 0; since_rise = 0; stable = 0; en_seen = 1'b0;
      end else begin
        since_rise++;
        stable  = (sd_w[g] === prev_sd) ? stable + 1 : 1;
        prev_sd = sd_w[g];
        if (cp_w[g]) high_len++;
        if (cp_w[g] && !prev_cp) begin
          n_tests++;
          if (bit_q.size() == 0) begin
            n_fail++; $display("FAIL ch%0d unexpected cp rise: got rise, required none", g);
          end else begin
            exp_b = bit_q.pop_front();
            if (sd_w[g] !== exp_b) begin
              n_fail++; $display("FAIL ch%0d bit %0d value: got %b, required %b", g, rises, sd_w[g], exp_b);
            end
          end
          n_tests++;
          if (stable < 6) begin
            n_fail++; $display("FAIL ch%0d setup bit %0d: stable %0d samples, required >= 6", g, rises, stable);
          end
          if (rises > 0) begin
            n_tests++;
            if (since_rise != 55) begin
              n_fail++; $display("FAIL ch%0d cp period: got %0d, required 55", g, since_rise);
            end
          end
          rises++; since_rise = 0; high_len = 1; din = sd_w[g];
        end
        if (!cp_w[g] && prev_cp) begin
          n_tests++;
          if (high_len != 25) begin
            n_fail++; $display("FAIL ch%0d cp high time: got %0d, required 25", g, high_len);
          end
          n_tests++;
          if (stable < 31) begin
            n_fail++; $display("FAIL ch%0d hold to cp fall: stable %0d, required >= 31", g, stable);
          end
          chain = ((chain << 1) | {19'b0, din}) & MASK;
        end
        if (!lr[g] && !dn[g]) en_seen = en_seen | en_w[g];
        if (dn[g]) begin
          n_tests++;
          if (frame_q.size() == 0) begin
            n_fail++; $display("FAIL ch%0d unexpected done", g);
          end else begin
            exp_f = frame_q.pop_front();
            if (chain !== exp_f) begin
              n_fail++; $display("FAIL ch%0d parallel_out: got %h, required %h", g, chain, exp_f);
            end
          end
          n_tests++;
          if (rises != LEN) begin
            n_fail++; $display("FAIL ch%0d cp rise count: got %0d, required %0d", g, rises, LEN);
          end
          n_tests++;
          if (en_w[g] !== 1'b1 || en_seen) begin
            n_fail++; $display("FAIL ch%0d enable blanking: at done %b, seen during shift %b, required 1/0", g, en_w[g], en_seen);
          end
          rises = 0; en_seen = 1'b0;
        end
        prev_cp = cp_w[g];
      end
    end
  end

`ifdef I4003_READBACK_EN
  assign sr0 = mon[0].chain[9];
  assign sr1 = mon[1].chain[19];
`endif

  task automatic push_frame(input int g, input logic [19:0] d);
    int len = (g == 0) ? 10 : 20;
    for (int i = len - 1; i >= 0; i--) begin
      if (g == 0) mon[0].bit_q.push_back(d[i]);
      else        mon[1].bit_q.push_back(d[i]);
    end
    if (g == 0) mon[0].frame_q.push_back(d);
    else        mon[1].frame_q.push_back(d);
  endtask

  task automatic wait_done(input int g, output int cyc);
    cyc = 1;
    while (dn[g] !== 1'b1 && cyc < 3000) begin
      @(negedge sysclk);
      cyc++;
    end
    if (dn[g] !== 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL ch%0d done timeout: waited %0d cycles, required done", g, cyc);
    end
  endtask

  // Call at a falling edge with the channel idle.
  task automatic send(input int g, input logic [19:0] d);
    int cyc;
    int exp_cyc = (g == 0) ? 551 : 1101;
    n_tests++;
    if (lr[g] !== 1'b1) begin
      n_fail++; $display("FAIL ch%0d ready before accept: got %b, required 1", g, lr[g]);
    end
    if (g == 0) ld0 = d[9:0];
    else        ld1 = d;
    lv[g] = 1'b1;
    push_frame(g, d);
    @(negedge sysclk);
    lv[g] = 1'b0;
    n_tests++;
    if (lr[g] !== 1'b0) begin
      n_fail++; $display("FAIL ch%0d ready after accept: got %b, required 0", g, lr[g]);
    end
    wait_done(g, cyc);
    n_tests++;
    if (cyc != exp_cyc) begin
      n_fail++; $display("FAIL ch%0d done latency: got %0d, required %0d", g, cyc, exp_cyc);
    end
    @(negedge sysclk);
    n_tests++;
    if (dn[g] !== 1'b0 || lr[g] !== 1'b1 || en_w[g] !== 1'b1) begin
      n_fail++; $display("FAIL ch%0d after done: done/ready/enable %b%b%b, required 011", g, dn[g], lr[g], en_w[g]);
    end
  endtask

  task automatic test_reset;
    @(negedge sysclk);
    for (int g = 0; g < 2; g++) begin
      n_tests++;
      if ({lr[g], dn[g], cp_w[g], sd_w[g], en_w[g]} !== 5'b10000) begin
        n_fail++;
        $display("FAIL ch%0d reset state: ready/done/cp/sd/en %b%b%b%b%b, required 10000", g, lr[g], dn[g], cp_w[g], sd_w[g], en_w[g]);
      end
    end
    rst_n = 1'b1;
    @(negedge sysclk);
    ld0 = 10'h3C3;
    lv[0] = 1'b1;
    push_frame(0, 20'h003C3);
    @(negedge sysclk);
    lv[0] = 1'b0;
    repeat (64) @(negedge sysclk);
    n_tests++;
    if (cp_w[0] !== 1'b1) begin
      n_fail++; $display("FAIL mid-frame cp before reset: got %b, required 1", cp_w[0]);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({lr[0], cp_w[0], en_w[0], dn[0]} !== 4'b1000) begin
      n_fail++; $display("FAIL mid-frame reset: ready/cp/en/done %b%b%b%b, required 1000", lr[0], cp_w[0], en_w[0], dn[0]);
    end
    mon[0].bit_q.delete();
    mon[0].frame_q.delete();
    repeat (2) @(negedge sysclk);
    n_tests++;
    if (dn[0] !== 1'b0 || cp_w[0] !== 1'b0) begin
      n_fail++; $display("FAIL reset held: done/cp %b%b, required 00", dn[0], cp_w[0]);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge sysclk);
  endtask

  task automatic test_single_frame;
    send(0, 20'h002A5);
    n_tests++;
    if (mon[0].chain[9:0] !== 10'h2A5) begin
      n_fail++; $display("FAIL single frame parallel_out: got %h, required 2a5", mon[0].chain[9:0]);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    ld0 = 10'h3FF;
    lv[0] = 1'b1;
    push_frame(0, 20'h003FF);
    @(negedge sysclk);
    wait_done(0, cyc);
    n_tests++;
    if (cyc != 551) begin
      n_fail++; $display("FAIL b2b first latency: got %0d, required 551", cyc);
    end
    ld0 = 10'h000;
    push_frame(0, 20'h00000);
    n_tests++;
    if (lr[0] !== 1'b0) begin
      n_fail++; $display("FAIL b2b ready in done: got %b, required 0", lr[0]);
    end
    @(negedge sysclk);
    n_tests++;
    if (lr[0] !== 1'b1 || dn[0] !== 1'b0) begin
      n_fail++; $display("FAIL b2b idle cycle: ready/done %b%b, required 10", lr[0], dn[0]);
    end
    @(negedge sysclk);
    lv[0] = 1'b0;
    n_tests++;
    if (lr[0] !== 1'b0 || en_w[0] !== 1'b0) begin
      n_fail++; $display("FAIL b2b second accept: ready/enable %b%b, required 00", lr[0], en_w[0]);
    end
    wait_done(0, cyc);
    n_tests++;
    if (cyc != 551) begin
      n_fail++; $display("FAIL b2b second latency: got %0d, required 551", cyc);
    end
    @(negedge sysclk);
    n_tests++;
    if (mon[0].chain[9:0] !== 10'h000 || en_w[0] !== 1'b1) begin
      n_fail++; $display("FAIL b2b final: parallel_out %h enable %b, required 000 1", mon[0].chain[9:0], en_w[0]);
    end
  endtask

  task automatic test_two_chip;
    send(1, 20'hABCDE);
    n_tests++;
    if (mon[1].chain[19:10] !== 10'h2AF || mon[1].chain[9:0] !== 10'h0DE) begin
      n_fail++; $display("FAIL two chip: chip1 %h chip0 %h, required 2af 0de", mon[1].chain[19:10], mon[1].chain[9:0]);
    end
  endtask

`ifdef I4003_READBACK_EN
  task automatic test_readback;
    send(0, 20'h00155);
    n_tests++;
    if (rd0 !== 10'h000) begin
      n_fail++; $display("FAIL readback first: got %h, required 000", rd0);
    end
    send(0, 20'h000F0);
    n_tests++;
    if (rd0 !== 10'h155) begin
      n_fail++; $display("FAIL readback second: got %h, required 155", rd0);
    end
    send(1, 20'h12345);
    n_tests++;
    if (rd1 !== 20'hABCDE) begin
      n_fail++; $display("FAIL readback two chip: got %h, required abcde", rd1);
    end
  endtask
`endif

  initial begin
    #1 rst_n = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_two_chip();
`ifdef I4003_READBACK_EN
    test_readback();
`endif
    repeat (3) @(negedge sysclk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i4003_chain_driver.md
Name: i4003_chain_driver

Overview:
- Host-side driver for one or more cascaded i4003 shift registers.
- Accepts a parallel word and serializes it onto the chain's serial data and CP lines.
- Holds every CP phase long enough for the i4003's 250 ns internal latch delay, then drives the chain's parallel-output enable.
- Sits between a CPU output-port register (or test logic) and the i4003 pins.

Parameters:
- SYSCLK_TCY, 20, system clock period in ns.
- CHAIN_LEN, 10, total chain bits (10 per i4003; 20 for two chips).
- SETUP_NS, 100, data-valid time before each CP rise.
- CP_HIGH_NS, 500, CP high time; must exceed 250.
- CP_LOW_NS, 500, CP low time; must exceed 250.
- BLANK_DURING_SHIFT, 1, when 1, enable is deasserted while a frame shifts.

Ports:
- sysclk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- load_valid  in  1  request to send load_data.
- load_ready  out  1  driver idle; a frame is accepted when load_valid and load_ready are both high.
- load_data  in  CHAIN_LEN  word to place in the chain; bit CHAIN_LEN-1 lands in the last chip's bit 9.
- done  out  1  one-cycle pulse when a frame completes.
- cp  out  1  chain clock pulse.
- serial_data  out  1  chain serial input.
- enable  out  1  chain parallel-output enable.
- serial_return  in  1  serial_out of the last chip; used only with I4003_READBACK_EN.
- rd_data  out  CHAIN_LEN  previous chain contents; present only with I4003_READBACK_EN.

Behaviour:
- Clock and reset: one clock, sysclk. Reset is asynchronous and active-low on rst_n.
- Phase lengths: SETUP_CY = nstocy(SETUP_NS), HIGH_CY = nstocy(CP_HIGH_NS), LOW_CY = nstocy(CP_LOW_NS). Defaults give 5/25/25 cycles.
- Phase counter: single counter, width clog2 of the largest phase. Bit counter counts 0..CHAIN_LEN-1.
- Reset values: load_ready=1, done=0, cp=0, serial_data=0, enable=0, rd_data=0. State is IDLE; the shift register is cleared.
- IDLE:
  - load_ready=1.
  - On accept: capture load_data into a shift register, clear the bit counter, enter SETUP.
  - load_ready drops the cycle after accept.
- SETUP:
  - serial_data = shift register MSB, presented from the first cycle of SETUP.
  - cp=0. Lasts SETUP_CY cycles, then HIGH.
- HIGH:
  - cp=1 for HIGH_CY cycles. serial_data is held stable for the whole phase.
  - Then LOW.
- LOW:
  - cp=0 for LOW_CY cycles.
  - At exit, shift the register left by one.
  - If bit counter = CHAIN_LEN-1: go to DONE. Otherwise increment the counter and go to SETUP.
- DONE:
  - Single cycle: done=1, enable=1, serial_data=0. Then IDLE.
- Latency: accept at edge 0 → done high for the cycle after CHAIN_LEN*(SETUP_CY+HIGH_CY+LOW_CY) cycles (550 with defaults).
- Enable:
  - With BLANK_DURING_SHIFT=1: enable drops the cycle after accept and rises in DONE.
  - With BLANK_DURING_SHIFT=0: enable rises at the first DONE and stays high until reset.
- cp, serial_data and enable are registered outputs; no glitches.
- load_valid while busy is ignored; there is no queueing.
- load_valid held high at DONE is accepted on the first IDLE cycle after DONE, never in the DONE cycle itself.
- Reset mid-frame: immediate return to IDLE with cp=0 and enable=0. The chain contents are then undefined; software re-sends a frame.
- CHAIN_LEN=1 is legal: one bit per frame.

Optional Feature:
- Macro I4003_READBACK_EN.
- When defined:
  - serial_return is sampled on the last cycle of each SETUP phase. The chain's serial_out then reflects the previous CP fall plus the latch delay.
  - Sampled bits are shifted into a capture register, MSB first.
  - The capture register is copied to rd_data in DONE.
  - rd_data therefore equals the chain contents before the frame. It is undefined for the first frame after power-up.
- When undefined: serial_return and rd_data are absent; no sampling logic is built.

Test Plan:
- Reset: rst_n low during a frame → cp=0, enable=0, load_ready=1 within the same cycle; no done.
- Single frame, CHAIN_LEN=10, load_data=10'h2A5 → exactly 10 CP rises, each HIGH 25 cycles and LOW 25 cycles. Bench i4003 model shows parallel_out=10'h2A5 after done; done at cycle 551.
- Setup/hold: check serial_data stable from 5 cycles before each cp rise until its fall. Bit order MSB first: 1,0,1,0,1,0,0,1,0,1.
- Back-to-back: load_valid held high with 10'h3FF then 10'h000 → second accept only after DONE. Enable low throughout the second shift (BLANK_DURING_SHIFT=1), then high; final parallel_out=0.
- Two-chip chain, CHAIN_LEN=20, data 20'hABCDE → chip1 parallel_out=10'h2AF, chip0 parallel_out=10'h0DE.
- With I4003_READBACK_EN: send 10'h155 then 10'h0F0 → rd_data=10'h155 after the second done.
